pipelined_rca_adder: RTL and testbench
======================================

PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in (add mode) or borrow-in (subtract mode).
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have ports cout and ovf, output, 1 bit each: unsigned carry-out and signed overflow.

Function
REQ-014 In add mode, {cout,sum} SHALL equal a + b + cin, computed modulo 2^(WIDTH+1).
REQ-015 In subtract mode, {cout,sum} SHALL equal a + ~b + !cin; cout=1 means no borrow.
REQ-016 ovf SHALL equal the carry into bit WIDTH-1 XOR cout.
REQ-017 Stage k SHALL resolve bits [k*CHUNK +: CHUNK] and register those sum bits plus the chunk carry; not-yet-added operand bits and sub SHALL travel with the stage.
REQ-018 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-019 Pipeline advance SHALL be global: advance = out_ready || !out_valid; in_ready SHALL equal advance.
REQ-020 Each stage SHALL carry a valid bit; bubbles SHALL propagate and are not collapsed.
REQ-021 Latency SHALL be exactly STAGES cycles from accepting edge to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-022 While out_valid && !out_ready, sum, cout, ovf and out_valid SHALL hold stable, and no stage SHALL change.
REQ-023 Results SHALL leave in acceptance order, with none lost or duplicated.
REQ-024 With STAGES=1, the block SHALL be a single registered adder with 1-cycle latency.
REQ-025 WIDTH % CHUNK != 0 or CHUNK < 1 SHALL be rejected at elaboration.

Reset
REQ-026 rst SHALL asynchronously clear all stage valid bits; out_valid, sum, cout and ovf SHALL read 0.
REQ-027 in_ready SHALL be 0 while rst is high and SHALL follow REQ-019 from the first edge after release.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.

Structure
REQ-029 The shared package adder_pkg SHALL hold the default WIDTH and CHUNK constants and a stage-payload struct (valid, partial sum, carry, remaining a/b, sub).
REQ-030 One combinational sub-module, rca_chunk (CHUNK-bit ripple of full-adder cells, with carry in/out and carry into MSB), SHALL be instantiated once per stage.

Verification
REQ-031 The bench SHALL drive a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-032 The bench SHALL drive a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
REQ-033 The bench SHALL drive a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-034 The bench SHALL send 8 back-to-back random transactions with out_ready toggling 1,0,1,0 -> all 8 results match the reference model in order, with outputs stable on stalled cycles.
REQ-035 The bench SHALL assert rst for 1 cycle with 3 operations in flight -> out_valid=0 immediately, and no result appears within 10 cycles after release with in_valid=0.
REQ-036 The bench SHALL rerun REQ-031 and REQ-032 with CHUNK=WIDTH=16 -> identical values with 1-cycle latency.

Source files
------------

// File: rtl/pipelined_rca_adder_pkg.sv
// adder_pkg: default geometry and stage payload shared by the pipelined ripple-carry adder
package adder_pkg;

    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_CHUNK = 4;

    // Payload one stage hands to the next at the default geometry; the top
    // declares the same layout sized by its own WIDTH parameter.
    typedef struct packed {
        logic                   valid;
        logic [ADDER_WIDTH-1:0] sum;
        logic                   carry;
        logic                   ovf;
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
        logic                   sub;
    } stage_t;

    // A bad CHUNK maps to one stage so the elaboration check, not a divide by zero, reports it.
    function automatic int stage_count(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// pipelined_rca_adder_if: operand/result valid-ready bus of the pipelined adder
interface pipelined_rca_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// rca_chunk: N-bit ripple of full-adder cells exposing carry-out and the carry into the MSB
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
    assign cmsb = c[N-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder: valid/ready add/sub pipeline resolving CHUNK bits per stage
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CHUNK = ADDER_CHUNK
) (
    input logic clk,
    input logic rst,
    pipelined_rca_adder_if.slave bus
);

    localparam int STAGES = stage_count(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_geometry
        $error("pipelined_rca_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
    } pipe_t;

    pipe_t st [STAGES];
    pipe_t nx [STAGES];
    logic  adv;

    // One advance signal for the whole pipe: move when the output slot is free or being taken.
    assign adv           = bus.out_ready || !st[STAGES-1].valid;
    assign bus.in_ready  = adv && !rst;
    assign bus.out_valid = st[STAGES-1].valid;
    assign bus.sum       = st[STAGES-1].sum;
    assign bus.cout      = st[STAGES-1].carry;
    assign bus.ovf       = st[STAGES-1].ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_t            src;
        pipe_t            nxt;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cm;

        // Subtract is a + ~b with the borrow-in inverted into a carry-in.
        if (k == 0) begin : g_head
            assign src = '{valid: bus.in_valid, sum: '0, carry: bus.cin ^ bus.sub, ovf: 1'b0,
                           a: bus.a, b: bus.b, sub: bus.sub};
        end else begin : g_body
            assign src = st[k-1];
        end

        rca_chunk #(.N(CHUNK)) u_chunk (
            .a    (src.a[k*CHUNK +: CHUNK]),
            .b    (src.b[k*CHUNK +: CHUNK] ^ {CHUNK{src.sub}}),
            .cin  (src.carry),
            .sum  (s),
            .cout (co),
            .cmsb (cm)
        );

        // Fold this chunk's sum bits and carry into the payload for the next stage.
        always_comb begin
            nxt = src;
            nxt.sum[k*CHUNK +: CHUNK] = s;
            nxt.carry = co;
            nxt.ovf = cm ^ co;
        end

        assign nx[k] = nxt;
    end

    // All stages step together; a stall freezes every stage and reset drops in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
        end else if (adv) begin
            st <= nx;
        end
    end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb_pipelined_rca_adder: directed and random checks of the 4-stage and 1-stage adder builds
module tb_pipelined_rca_adder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipelined_rca_adder_if #(.WIDTH(16)) bus ();
    pipelined_rca_adder_if #(.WIDTH(16)) bus1 ();

    assign bus1.in_valid  = bus.in_valid;
    assign bus1.a         = bus.a;
    assign bus1.b         = bus.b;
    assign bus1.cin       = bus.cin;
    assign bus1.sub       = bus.sub;
    assign bus1.out_ready = bus.out_ready;

    pipelined_rca_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipelined_rca_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, ovf, sum} from plain integer arithmetic and the operand-sign overflow rule.
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic c, input logic s);
        logic [15:0] yy;
        logic [16:0] t;
        logic        o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + 17'(s ? !c : c);
        o  = (x[15] == yy[15]) && (t[15] != x[15]);
        return {t[16], o, t[15:0]};
    endfunction

    task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic ts, input logic [17:0] expv);
        int          lat4;
        int          lat1;
        logic [17:0] r4;
        logic [17:0] r1;
        lat4 = 0;
        lat1 = 0;
        r4   = '0;
        r1   = '0;
        @(negedge clk);
        bus.a = ta;
        bus.b = tb;
        bus.cin = tc;
        bus.sub = ts;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_model"}, 32'(ref_model(ta, tb, tc, ts)), 32'(expv));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 20 && (lat4 == 0 || lat1 == 0); n++) begin
            @(negedge clk);
            if (lat4 == 0 && bus.out_valid) begin
                lat4 = n;
                r4 = {bus.cout, bus.ovf, bus.sum};
            end
            if (lat1 == 0 && bus1.out_valid) begin
                lat1 = n;
                r1 = {bus1.cout, bus1.ovf, bus1.sum};
            end
        end
        check({tag, "_latency4"}, 32'(lat4), 32'd4);
        check({tag, "_result4"}, 32'(r4), 32'(expv));
        check({tag, "_latency1"}, 32'(lat1), 32'd1);
        check({tag, "_result1"}, 32'(r1), 32'(expv));
    endtask

    logic [15:0] ra [8];
    logic [15:0] rb [8];
    logic        rc [8];
    logic        rs [8];
    logic [17:0] exp_q [$];
    logic [18:0] held;
    logic        prev_stall;
    int          idx;
    int          got;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_out_valid1", 32'(bus1.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        directed("add_cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2234});

        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rc[i] = 1'($urandom);
            rs[i] = 1'($urandom);
        end
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall)
                check("stall_hold", 32'({bus.out_valid, bus.cout, bus.ovf, bus.sum}), 32'(held));
            bus.out_ready = (cyc % 2 == 0);
            bus.in_valid = (idx < 8);
            if (idx < 8) begin
                bus.a = ra[idx];
                bus.b = rb[idx];
                bus.cin = rc[idx];
                bus.sub = rs[idx];
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("rand_result", 32'({bus.cout, bus.ovf, bus.sum}), 32'(exp_q.pop_front()));
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(ra[idx], rb[idx], rc[idx], rs[idx]));
                idx++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = {bus.out_valid, bus.cout, bus.ovf, bus.sum};
        end
        check("rand_count", 32'(got), 32'd8);
        bus.in_valid = 1'b0;

        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int n = 0; n < 10 && !bus.out_valid; n++) @(negedge clk);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_sum", 32'(bus.sum), 32'd0);
        check("async_rst_cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("async_rst_valid1", 32'(bus1.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("post_reset_no_result", 32'({bus.out_valid, bus1.out_valid}), 32'd0);
        end
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
